ex_commit_stage: RTL and testbench
==================================

# ex_commit_stage

Execute/memory boundary stage directly downstream of the ALU. Registers each ALU result into a single-entry handoff to the memory stage. Holds the architectural condition codes (icc) and Y register that feed back into the ALU. Resolves control transfers: it issues the fetch redirect, executes or annuls the delay slot, and drops wrong-path instructions.

## Interface
Parameters:
- SQUASH_DEPTH, 2: number of valid wrong-path instructions, beyond the delay slot, dropped after a redirect (1..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept this cycle
- in_res  in  64  ALU result; only [31:0] is used
- in_pc  in  32  instruction PC
- in_rd  in  5  destination register
- in_op  in  2  op field
- in_op3  in  6  op3 field
- in_op2  in  3  op2 field
- in_store_data  in  32  rd value for stores
- in_target  in  32  CTI target address
- in_mux_sel  in  1  taken CTI
- in_annul  in  1  ALU annul output
- in_icc  in  4  {n,z,v,c} from ALU
- in_y  in  32  Y from ALU
- icc_q  out  4  committed icc to ALU
- y_q  out  32  committed Y to ALU
- out_valid, out_ready  out/in  1  memory-stage handshake
- out_res, out_store_data, out_pc  out  32  registered payload
- out_rd  out  5  registered rd
- out_op, out_op3  out  2/6  registered opcode
- redirect  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  redirect target
- err_dcti  out  1  one-cycle pulse when a CTI in a delay slot is accepted
- fwd_valid, fwd_rd, fwd_res  out  1/5/32  bypass to operand read (see Configuration)

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Bicc is defined as op=00, op2=010.
- FSM states:
  - RUN: normal operation.
  - DSLOT_EXEC: the next accepted instruction is the delay slot and is executed.
  - DSLOT_ANNUL: the next accepted instruction is the delay slot and is dropped.
  - DRAIN: drop instructions until the drop counter reaches 0.
- Transitions from RUN on an accepted instruction:
  - Bicc with in_annul=1 → DSLOT_ANNUL. This covers untaken conditional branches with a=1 and BA with a=1.
  - Otherwise, if in_mux_sel=1 → DSLOT_EXEC.
- Leaving DSLOT_EXEC or DSLOT_ANNUL on the next accepted instruction:
  - If a redirect is pending → DRAIN, with the drop counter set to SQUASH_DEPTH.
  - Otherwise → RUN.
- DRAIN: each accepted instruction decrements the counter. At 1 → 0, return to RUN.
- Redirect: asserted the cycle after a CTI with in_mux_sel=1 is accepted in RUN; redirect_pc = in_target.
- Dropped instructions (annulled slot, DRAIN) are consumed (in_ready honoured) but:
  - do not load the output register;
  - do not update icc_q or y_q;
  - never redirect.
- Kept instructions:
  - icc_q ← in_icc and y_q ← in_y on accept.
  - The payload loads with out_res = in_res[31:0].
- CTI accepted in DSLOT_EXEC:
  - Its redirect is suppressed and it is treated as ordinary.
  - err_dcti pulses.
- out_valid clears on out_ready when no new accept occurs in the same cycle. A simultaneous drain and accept keeps out_valid=1 with the new payload.

## Timing
- Reset values: out_valid=0, redirect=0, err_dcti=0, icc_q=0, y_q=0, redirect_pc=0, payload=0, FSM=RUN, drop counter=0, fwd_valid=0.
- Latency: 1 cycle from accept to out_valid, and to updated icc_q/y_q. A subcc→bne pair on consecutive cycles sees the new icc.
- redirect is high for exactly 1 cycle, with no dependence on out_ready.
- Backpressure: with out_ready=0 and out_valid=1, in_ready=0. State and registers hold.
- Reset asserted mid-operation: all state returns to reset values at that edge. A pending drain is discarded and the in-flight accept is ignored.
- Drop counter width: 3 bits. It never underflows; the DRAIN exit occurs at 1.

## Configuration
- EXCOMMIT_BYPASS_EN defined:
  - fwd_valid = out_valid && out_rd≠0.
  - fwd_rd = out_rd.
  - fwd_res = out_res.
  - fwd_valid is forced 0 for loads (op=11 with op3[2]=0).
- EXCOMMIT_BYPASS_EN undefined: fwd_valid, fwd_rd and fwd_res are tied to 0.

## Test plan
- Reset, then ADDcc with res=0, icc=0100 → out_valid 1 cycle later, out_res=0, icc_q=0100.
- CALL with pc=0x100, target=0x200, followed by 4 valid instructions, SQUASH_DEPTH=2:
  - redirect pulses 1 cycle with redirect_pc=0x200.
  - 1st instruction (delay slot) is kept; 2nd and 3rd are dropped; 4th is kept.
- BNE untaken with annul=1 → next instruction is dropped, icc_q is unchanged, no redirect.
- out_ready=0 for 3 cycles while out_valid=1 → in_ready=0 and the payload is stable. out_ready=1 with in_valid=1 in the same cycle → the new payload loads and out_valid stays 1.
- Taken BA in the delay slot of a CALL → err_dcti pulses and only the CALL redirect is issued.
- Reset during DRAIN with counter=1 → the next instruction is kept, with state=RUN and icc_q=0.

Source files
------------

// File: rtl/ex_commit_stage_if.sv
// ex_commit_stage_if: the ALU-side input bundle, the memory-stage handoff,
// the feedback registers and the redirect/bypass outputs of the commit stage.
// master: the surrounding pipeline (ALU, memory stage, fetch).
// slave:  the commit stage itself.
interface ex_commit_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_res;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [1:0]  in_op;
    logic [5:0]  in_op3;
    logic [2:0]  in_op2;
    logic [31:0] in_store_data;
    logic [31:0] in_target;
    logic        in_mux_sel;
    logic        in_annul;
    logic [3:0]  in_icc;
    logic [31:0] in_y;
    logic [3:0]  icc_q;
    logic [31:0] y_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [31:0] out_store_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [1:0]  out_op;
    logic [5:0]  out_op3;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        err_dcti;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_res;

    modport master (
        output in_valid, in_res, in_pc, in_rd, in_op, in_op3, in_op2,
               in_store_data, in_target, in_mux_sel, in_annul, in_icc, in_y,
               out_ready,
        input  in_ready, icc_q, y_q, out_valid, out_res, out_store_data,
               out_pc, out_rd, out_op, out_op3, redirect, redirect_pc,
               err_dcti, fwd_valid, fwd_rd, fwd_res
    );

    modport slave (
        input  in_valid, in_res, in_pc, in_rd, in_op, in_op3, in_op2,
               in_store_data, in_target, in_mux_sel, in_annul, in_icc, in_y,
               out_ready,
        output in_ready, icc_q, y_q, out_valid, out_res, out_store_data,
               out_pc, out_rd, out_op, out_op3, redirect, redirect_pc,
               err_dcti, fwd_valid, fwd_rd, fwd_res
    );
endinterface

// File: rtl/ex_commit_stage.sv
// ex_commit_stage: execute/memory boundary. Single-entry payload register,
// committed icc/Y, delay-slot handling and wrong-path squash after redirects.
// Optional operand bypass from the payload register: EXCOMMIT_BYPASS_EN.
//
// state       | meaning
// ------------+---------------------------------------------------------
// RUN         | normal operation, every accepted instruction is kept
// DSLOT_EXEC  | next accepted instruction is the delay slot, executed
// DSLOT_ANNUL | next accepted instruction is the delay slot, dropped
// DRAIN       | drop accepted instructions until drop_cnt reaches 0
module ex_commit_stage #(
    parameter int unsigned SQUASH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    ex_commit_stage_if.slave bus
);
    typedef enum logic [1:0] {RUN, DSLOT_EXEC, DSLOT_ANNUL, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  drop_cnt_q, drop_cnt_d;
    logic        pend_q, pend_d;
    logic        accept, keep, redir_set, dcti;
    logic        is_bicc, is_cti;

    logic        out_valid_q;
    logic [31:0] out_res_q, out_store_data_q, out_pc_q;
    logic [4:0]  out_rd_q;
    logic [1:0]  out_op_q;
    logic [5:0]  out_op3_q;
    logic [3:0]  icc_q;
    logic [31:0] y_q;
    logic        redirect_q, err_dcti_q;
    logic [31:0] redirect_pc_q;
    logic        unused_res_hi;

    assign unused_res_hi = ^bus.in_res[63:32];

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_bicc      = (bus.in_op == 2'b00) && (bus.in_op2 == 3'b010);
    // Bicc, CALL and JMPL are the transfers that may not sit in a delay slot.
    assign is_cti       = is_bicc || (bus.in_op == 2'b01) ||
                          ((bus.in_op == 2'b10) && (bus.in_op3 == 6'b111000));

    // State, drop counter and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            drop_cnt_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            pend_q     <= pend_d;
        end
    end

    // Next-state decode plus keep/drop, redirect and delay-slot-CTI decisions.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        pend_d     = pend_q;
        keep       = 1'b0;
        redir_set  = 1'b0;
        dcti       = 1'b0;
        if (accept) begin
            unique case (state_q)
                RUN: begin
                    keep = 1'b1;
                    if (bus.in_mux_sel) begin
                        redir_set = 1'b1;
                        pend_d    = 1'b1;
                    end
                    if (is_bicc && bus.in_annul) state_d = DSLOT_ANNUL;
                    else if (bus.in_mux_sel)     state_d = DSLOT_EXEC;
                end
                DSLOT_EXEC, DSLOT_ANNUL: begin
                    // A CTI in an executed slot is kept as an ordinary op.
                    keep   = (state_q == DSLOT_EXEC);
                    dcti   = (state_q == DSLOT_EXEC) && is_cti;
                    pend_d = 1'b0;
                    if (pend_q) begin
                        state_d    = DRAIN;
                        drop_cnt_d = 3'(SQUASH_DEPTH);
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (drop_cnt_q != 3'd0) drop_cnt_d = drop_cnt_q - 3'd1;
                    if (drop_cnt_q <= 3'd1) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Payload, icc/Y and redirect registers; only kept instructions load.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_res_q        <= '0;
            out_store_data_q <= '0;
            out_pc_q         <= '0;
            out_rd_q         <= '0;
            out_op_q         <= '0;
            out_op3_q        <= '0;
            icc_q            <= '0;
            y_q              <= '0;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
            err_dcti_q       <= 1'b0;
        end else begin
            redirect_q <= redir_set;
            err_dcti_q <= dcti;
            if (redir_set) redirect_pc_q <= bus.in_target;
            if (keep) begin
                out_valid_q      <= 1'b1;
                out_res_q        <= bus.in_res[31:0];
                out_store_data_q <= bus.in_store_data;
                out_pc_q         <= bus.in_pc;
                out_rd_q         <= bus.in_rd;
                out_op_q         <= bus.in_op;
                out_op3_q        <= bus.in_op3;
                icc_q            <= bus.in_icc;
                y_q              <= bus.in_y;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_res        = out_res_q;
    assign bus.out_store_data = out_store_data_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_rd         = out_rd_q;
    assign bus.out_op         = out_op_q;
    assign bus.out_op3        = out_op3_q;
    assign bus.icc_q          = icc_q;
    assign bus.y_q            = y_q;
    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.err_dcti       = err_dcti_q;

`ifdef EXCOMMIT_BYPASS_EN
    // Loads have no result yet at this point, so they never forward.
    assign bus.fwd_valid = out_valid_q && (out_rd_q != 5'd0) &&
                           !((out_op_q == 2'b11) && !out_op3_q[2]);
    assign bus.fwd_rd    = out_rd_q;
    assign bus.fwd_res   = out_res_q;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = '0;
    assign bus.fwd_res   = '0;
`endif
endmodule

// File: tb/tb_ex_commit_stage.sv
// tb_ex_commit_stage: directed vector table plus hand-written sequences for
// backpressure and reset during drain.
module tb_ex_commit_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_commit_stage_if bus ();
    ex_commit_stage #(.SQUASH_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [1:0] OP_BR = 2'b00, OP_CALL = 2'b01, OP_ALU = 2'b10;
    localparam logic [2:0] BICC = 3'b010;

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [2:0]  op2;
        logic        mux;
        logic        ann;
        logic [31:0] res;
        logic [31:0] tgt;
        logic [3:0]  icc;
        logic [31:0] y;
        logic        e_ov;
        logic [31:0] e_res;
        logic [3:0]  e_icc;
        logic [31:0] e_y;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_err;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [2:0] op2, logic mux,
                                logic ann, logic [31:0] res, logic [31:0] tgt,
                                logic [3:0] icc, logic [31:0] y, logic e_ov,
                                logic [31:0] e_res, logic [3:0] e_icc, logic [31:0] e_y,
                                logic e_red, logic [31:0] e_rpc, logic e_err);
        vec_t t;
        t = '{v, op, op2, mux, ann, res, tgt, icc, y, e_ov, e_res, e_icc, e_y,
              e_red, e_rpc, e_err};
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [1:0] op, logic [2:0] op2, logic mux,
                         logic ann, logic [31:0] res, logic [31:0] tgt,
                         logic [3:0] icc, logic [31:0] y);
        bus.in_valid      = v;
        bus.in_op         = op;
        bus.in_op2        = op2;
        bus.in_op3        = (op == OP_ALU) ? 6'h10 : 6'h00;
        bus.in_mux_sel    = mux;
        bus.in_annul      = ann;
        bus.in_res        = {32'hDEAD_BEEF, res};
        bus.in_target     = tgt;
        bus.in_icc        = icc;
        bus.in_y          = y;
        bus.in_pc         = res + 32'h1000;
        bus.in_store_data = ~res;
        bus.in_rd         = 5'd1;
    endtask

    logic exp_fwd;

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        drive(0, OP_ALU, 3'd0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'h0,   32'h0,   4'h4, 32'h11, 1, 32'h0,   4'h4, 32'h11, 0, 32'h0,   0);
        vecs[1]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'h5,   32'h0,   4'h0, 32'h22, 1, 32'h5,   4'h0, 32'h22, 0, 32'h0,   0);
        vecs[2]  = mk(1, OP_CALL, 3'd0, 1, 0, 32'h100, 32'h200, 4'h0, 32'h22, 1, 32'h100, 4'h0, 32'h22, 1, 32'h200, 0);
        vecs[3]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'h7,   32'h0,   4'h0, 32'h22, 1, 32'h7,   4'h0, 32'h22, 0, 32'h200, 0);
        vecs[4]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'h8,   32'h0,   4'h8, 32'h33, 0, 32'h7,   4'h0, 32'h22, 0, 32'h200, 0);
        vecs[5]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'h9,   32'h0,   4'h8, 32'h33, 0, 32'h7,   4'h0, 32'h22, 0, 32'h200, 0);
        vecs[6]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'hA,   32'h0,   4'h2, 32'h44, 1, 32'hA,   4'h2, 32'h44, 0, 32'h200, 0);
        vecs[7]  = mk(1, OP_BR,   BICC, 0, 1, 32'hB,   32'h600, 4'h2, 32'h44, 1, 32'hB,   4'h2, 32'h44, 0, 32'h200, 0);
        vecs[8]  = mk(1, OP_ALU,  3'd0, 0, 0, 32'hC,   32'h0,   4'hF, 32'h55, 0, 32'hB,   4'h2, 32'h44, 0, 32'h200, 0);
        vecs[9]  = mk(0, OP_ALU,  3'd0, 0, 0, 32'h0,   32'h0,   4'h0, 32'h0,  0, 32'hB,   4'h2, 32'h44, 0, 32'h200, 0);
        vecs[10] = mk(1, OP_CALL, 3'd0, 1, 0, 32'h140, 32'h300, 4'h2, 32'h44, 1, 32'h140, 4'h2, 32'h44, 1, 32'h300, 0);
        vecs[11] = mk(1, OP_BR,   BICC, 1, 0, 32'h144, 32'h400, 4'h2, 32'h44, 1, 32'h144, 4'h2, 32'h44, 0, 32'h300, 1);
        vecs[12] = mk(1, OP_ALU,  3'd0, 0, 0, 32'hD,   32'h0,   4'hF, 32'h55, 0, 32'h144, 4'h2, 32'h44, 0, 32'h300, 0);
        vecs[13] = mk(1, OP_ALU,  3'd0, 0, 0, 32'hE,   32'h0,   4'hF, 32'h55, 0, 32'h144, 4'h2, 32'h44, 0, 32'h300, 0);
        vecs[14] = mk(1, OP_ALU,  3'd0, 0, 0, 32'hF,   32'h0,   4'h1, 32'h66, 1, 32'hF,   4'h1, 32'h66, 0, 32'h300, 0);
        vecs[15] = mk(1, OP_BR,   BICC, 1, 1, 32'h10,  32'h500, 4'h1, 32'h66, 1, 32'h10,  4'h1, 32'h66, 1, 32'h500, 0);
        vecs[16] = mk(1, OP_ALU,  3'd0, 0, 0, 32'h11,  32'h0,   4'hF, 32'h55, 0, 32'h10,  4'h1, 32'h66, 0, 32'h500, 0);
        vecs[17] = mk(0, OP_ALU,  3'd0, 0, 0, 32'h0,   32'h0,   4'h0, 32'h0,  0, 32'h10,  4'h1, 32'h66, 0, 32'h500, 0);
        vecs[18] = mk(1, OP_ALU,  3'd0, 0, 0, 32'h12,  32'h0,   4'hF, 32'h55, 0, 32'h10,  4'h1, 32'h66, 0, 32'h500, 0);
        vecs[19] = mk(1, OP_ALU,  3'd0, 0, 0, 32'h13,  32'h0,   4'hF, 32'h55, 0, 32'h10,  4'h1, 32'h66, 0, 32'h500, 0);
        vecs[20] = mk(1, OP_ALU,  3'd0, 0, 0, 32'h14,  32'h0,   4'h3, 32'h77, 1, 32'h14,  4'h3, 32'h77, 0, 32'h500, 0);

        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_icc", 32'(bus.icc_q), 32'd0);
        chk("rst_y", bus.y_q, 32'd0);
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_err_dcti", 32'(bus.err_dcti), 32'd0);
        chk("rst_out_res", bus.out_res, 32'd0);
        chk("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].op2, vecs[i].mux, vecs[i].ann,
                  vecs[i].res, vecs[i].tgt, vecs[i].icc, vecs[i].y);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_res", i), bus.out_res, vecs[i].e_res);
            chk($sformatf("v%0d_icc", i), 32'(bus.icc_q), 32'(vecs[i].e_icc));
            chk($sformatf("v%0d_y", i), bus.y_q, vecs[i].e_y);
            chk($sformatf("v%0d_redirect", i), 32'(bus.redirect), 32'(vecs[i].e_red));
            chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d_err_dcti", i), 32'(bus.err_dcti), 32'(vecs[i].e_err));
`ifdef EXCOMMIT_BYPASS_EN
            exp_fwd = vecs[i].e_ov;
`else
            exp_fwd = 1'b0;
`endif
            chk($sformatf("v%0d_fwd_valid", i), 32'(bus.fwd_valid), 32'(exp_fwd));
        end

        // Backpressure: payload 0x14 held while out_ready is low.
        bus.out_ready = 1'b0;
        drive(1, OP_ALU, 3'd0, 0, 0, 32'h22, 32'h0, 4'h5, 32'h99);
        #1;
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_out_res", k), bus.out_res, 32'h14);
            chk($sformatf("bp%0d_icc", k), 32'(bus.icc_q), 32'h3);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_new_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_new_res", bus.out_res, 32'h22);
        chk("bp_new_store", bus.out_store_data, ~32'h22);
        chk("bp_new_pc", bus.out_pc, 32'h1022);
        chk("bp_new_rd", 32'(bus.out_rd), 32'd1);
        chk("bp_new_icc", 32'(bus.icc_q), 32'h5);
        chk("bp_new_y", bus.y_q, 32'h99);
        drive(0, OP_ALU, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);

        // Reset while DRAIN holds one remaining drop.
        drive(1, OP_CALL, 3'd0, 1, 0, 32'h180, 32'h700, 4'h5, 32'h99);
        @(negedge clk);
        chk("rd_call_redirect", 32'(bus.redirect), 32'd1);
        chk("rd_call_pc", bus.redirect_pc, 32'h700);
        drive(1, OP_ALU, 3'd0, 0, 0, 32'h41, 32'h0, 4'h5, 32'h99);
        @(negedge clk);
        chk("rd_slot_res", bus.out_res, 32'h41);
        drive(1, OP_ALU, 3'd0, 0, 0, 32'h42, 32'h0, 4'hE, 32'hAA);
        @(negedge clk);
        chk("rd_drop_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        drive(1, OP_ALU, 3'd0, 0, 0, 32'h43, 32'h0, 4'h6, 32'hBB);
        @(negedge clk);
        chk("rd_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rd_rst_icc", 32'(bus.icc_q), 32'd0);
        chk("rd_rst_y", bus.y_q, 32'd0);
        chk("rd_rst_res", bus.out_res, 32'd0);
        chk("rd_rst_rpc", bus.redirect_pc, 32'd0);
        reset = 1'b0;
        drive(1, OP_ALU, 3'd0, 0, 0, 32'h44, 32'h0, 4'h9, 32'h88);
        @(negedge clk);
        chk("rd_after_valid", 32'(bus.out_valid), 32'd1);
        chk("rd_after_res", bus.out_res, 32'h44);
        chk("rd_after_icc", 32'(bus.icc_q), 32'h9);
        chk("rd_after_y", bus.y_q, 32'h88);
        chk("rd_after_redirect", 32'(bus.redirect), 32'd0);
        drive(0, OP_ALU, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
